// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder_arbiter block.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder.sv
// Registered unsigned adder: full-width sum and valid one cycle after i_valid.
module adder #(
  parameter int g_data_width = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [g_data_width-1:0] i_A,
  input  logic [g_data_width-1:0] i_B,
  output logic                    o_valid,
  output logic [g_data_width:0]   o_C
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_C     <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_C <= {1'b0, i_A} + {1'b0, i_B};
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request above i_last, wrapping.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int g_num_req = 4
) (
  input  logic [g_num_req-1:0]           i_req,
  input  logic [id_width(g_num_req)-1:0] i_last,
  output logic [g_num_req-1:0]           o_grant,
  output logic [id_width(g_num_req)-1:0] o_idx,
  output logic                           o_any
);

  localparam int IW = id_width(g_num_req);

  int   w_pos;
  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_pos   = 0;
    w_found = 1'b0;
    for (int off = 1; off <= g_num_req; off++) begin
      w_pos = (int'(i_last) + off) % g_num_req;
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IW'(w_pos);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one registered adder among g_num_req requesters.
// Optional per-requester grant counters are enabled with ADDER_ARB_STATS_EN.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int g_data_width = 8,
  parameter int g_num_req    = 4,
  parameter int g_cnt_width  = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [g_num_req-1:0]              i_req_valid,
  input  logic [g_num_req*g_data_width-1:0] i_req_A,
  input  logic [g_num_req*g_data_width-1:0] i_req_B,
  output logic [g_num_req-1:0]              o_req_ready,
  output logic                              o_rsp_valid,
  output logic [g_data_width:0]             o_rsp_C,
  output logic [id_width(g_num_req)-1:0]    o_rsp_id,
  input  logic                              i_rsp_ready
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [g_num_req*g_cnt_width-1:0]  o_grant_cnt
`endif
);

  localparam int IW = id_width(g_num_req);
  localparam logic [IW-1:0] LAST_RST = IW'(g_num_req - 1);

  arb_state_t                r_state, w_next;
  logic [IW-1:0]             r_last_grant;
  logic                      r_rsp_valid;
  logic [g_data_width:0]     r_rsp_C;
  logic [IW-1:0]             r_rsp_id;

  logic [g_num_req-1:0]      w_grant;
  logic [IW-1:0]             w_grant_idx;
  logic                      w_any;
  logic                      w_add_vin;
  logic [g_data_width-1:0]   w_add_A, w_add_B;
  logic                      w_add_vout;
  logic [g_data_width:0]     w_add_C;

  rr_arbiter #(.g_num_req(g_num_req)) u_rr (
    .i_req   (i_req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  adder #(.g_data_width(g_data_width)) u_adder (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_add_vin),
    .i_A     (w_add_A),
    .i_B     (w_add_B),
    .o_valid (w_add_vout),
    .o_C     (w_add_C)
  );

  // One-hot AND-OR operand mux avoids a variable-offset part-select.
  always_comb begin
    w_add_A = '0;
    w_add_B = '0;
    for (int k = 0; k < g_num_req; k++) begin
      if (w_grant[k]) begin
        w_add_A = i_req_A[k*g_data_width +: g_data_width];
        w_add_B = i_req_B[k*g_data_width +: g_data_width];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = '0;
    w_add_vin   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          o_req_ready = w_grant;
          w_add_vin   = 1'b1;
          w_next      = WAIT;
        end
      end
      WAIT:    w_next = RESP;
      RESP:    if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_last_grant <= LAST_RST;
      r_rsp_valid  <= 1'b0;
      r_rsp_C      <= '0;
      r_rsp_id     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_last_grant <= w_grant_idx;
      end
      if (r_state == WAIT) begin
        r_rsp_valid <= 1'b1;
        r_rsp_C     <= w_add_C;
        r_rsp_id    <= r_last_grant;
      end
      if (r_state == RESP && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // The adder must deliver its result in the cycle after issue.
  a_adder_valid_in_wait: assert property (
    @(posedge i_clk) disable iff (i_rst) (r_state == WAIT) |-> w_add_vout
  );

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_C     = r_rsp_C;
  assign o_rsp_id    = r_rsp_id;

`ifdef ADDER_ARB_STATS_EN
  logic [g_num_req-1:0][g_cnt_width-1:0] r_cnt;

  // Saturating counters: stop at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < g_num_req; k++) begin
        if (o_req_ready[k] && (r_cnt[k] != {g_cnt_width{1'b1}})) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign o_grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (4 requesters, 8-bit operands).
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_A, req_B;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [8:0]  rsp_C;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
`ifdef ADDER_ARB_STATS_EN
  logic [7:0]  grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.g_data_width(8), .g_num_req(4), .g_cnt_width(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_A     (req_A),
    .i_req_B     (req_B),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_C     (rsp_C),
    .o_rsp_id    (rsp_id),
    .i_rsp_ready (rsp_ready)
`ifdef ADDER_ARB_STATS_EN
    ,
    .o_grant_cnt (grant_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
    req_A[k*8 +: 8] = a;
    req_B[k*8 +: 8] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_A = '0; req_B = '0; rsp_ready = 1'b0;
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    checks++; if (rsp_C !== 9'h000) begin errors++; $display("FAIL reset_rsp_C: got %h want 000", rsp_C); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
`ifdef ADDER_ARB_STATS_EN
    checks++; if (grant_cnt !== 8'h00) begin errors++; $display("FAIL reset_grant_cnt: got %h want 00", grant_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 8'h12, 8'h34); req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", rsp_valid); end
    checks++; if (rsp_C !== 9'h046) begin errors++; $display("FAIL single_C: got %h want 046", rsp_C); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp_c [4];
    int e;
    exp_c = '{9'h110, 9'h122, 9'h134, 9'h146};
    do_reset();
    set_req(0, 8'hC0, 8'h50); set_req(1, 8'hD1, 8'h51);
    set_req(2, 8'hE2, 8'h52); set_req(3, 8'hF3, 8'h53);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      e = t % 4;
      #1;
      checks++; if (req_ready !== (4'b0001 << e)) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", t, req_ready, 4'b0001 << e); end
      tick();
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_wait_ready[%0d]: got %b want 0000", t, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %0b want 1", t, rsp_valid); end
      checks++; if (rsp_id !== e[1:0]) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", t, rsp_id, e); end
      checks++; if (rsp_C !== exp_c[e]) begin errors++; $display("FAIL rr_C[%0d]: got %h want %h", t, rsp_C, exp_c[e]); end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_max();
    set_req(2, 8'hFF, 8'hFF); req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL max_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_C !== 9'h1FE) begin errors++; $display("FAIL max_C: got %h want 1fe", rsp_C); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL max_id: got %0d want 2", rsp_id); end
    tick();
    set_req(2, 8'h00, 8'h00); req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %0b want 1", rsp_valid); end
    checks++; if (rsp_C !== 9'h000) begin errors++; $display("FAIL zero_C: got %h want 000", rsp_C); end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(3, 8'h55, 8'hAA); set_req(0, 8'h01, 8'h02);
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, rsp_valid); end
      checks++; if (rsp_C !== 9'h0FF) begin errors++; $display("FAIL bp_C[%0d]: got %h want 0ff", i, rsp_C); end
      checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL bp_id[%0d]: got %0d want 3", i, rsp_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, req_ready); end
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b want 0", rsp_valid); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    set_req(2, 8'h07, 8'h09); req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_in_reset: got %0b want 0", rsp_valid); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_rsp: got %0b want 0", rsp_valid); end
    set_req(1, 8'h03, 8'h04); req_valid = 4'b0110;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_order: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL rm_id: got %0d want 1", rsp_id); end
    checks++; if (rsp_C !== 9'h007) begin errors++; $display("FAIL rm_C: got %h want 007", rsp_C); end
    tick();
  endtask

`ifdef ADDER_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    rsp_ready = 1'b1;
    set_req(3, 8'h01, 8'h01);
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b1000;
      #1;
      tick();
      req_valid = '0;
      tick();
      tick();
    end
    checks++; if (grant_cnt !== 8'hC0) begin errors++; $display("FAIL stats_cnt: got %h want c0", grant_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max();
    test_backpressure();
    test_reset_mid();
`ifdef ADDER_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
